// File: rtl/count_step_monitor.sv
// count_step_monitor
//   Receiving-side monitor for a 4-bit up/down counter bus. Each sample strobe
//   captures the count, classifies the wrap-around step from the previous
//   capture (HOLD / UP / DOWN / illegal), and drives a registered 7-segment
//   pattern of the captured value.
//
// Ports
//   CLK         in   system clock, rising edge
//   CLR         in   asynchronous active-low reset
//   sample_en   in   capture strobe for Q_in
//   Q_in[3:0]   in   counter value
//   step_valid  out  pulse: classification outputs updated this cycle
//   dir_up      out  last legal non-zero step was +1 (1) or -1 (0)
//   paused      out  HOLD_LIMIT or more consecutive zero steps seen
//   err         out  pulse: last step was illegal
//   err_count   out  saturating count of illegal steps
//   seg[6:0]    out  active-low {g,f,e,d,c,b,a} of last captured value

module count_step_monitor #(
    parameter int HOLD_LIMIT = 1,
    parameter int ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             sample_en,
    input  logic [3:0]       Q_in,
    output logic             step_valid,
    output logic             dir_up,
    output logic             paused,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [6:0]       seg
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_LIMIT);
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic {
        ST_EMPTY = 1'b0,   // no previous sample held yet
        ST_TRACK = 1'b1    // prev_q is valid, steps are classified
    } state_t;

    state_t state_q, state_d;

    logic [3:0]       prev_q,       prev_d;
    logic [3:0]       hold_cnt_q,   hold_cnt_d;
    logic             step_valid_q, step_valid_d;
    logic             dir_up_q,     dir_up_d;
    logic             paused_q,     paused_d;
    logic             err_q,        err_d;
    logic [ERR_W-1:0] err_count_q,  err_count_d;
    logic [6:0]       seg_q,        seg_d;

    logic [3:0] step;
    logic [3:0] hold_inc;

    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (sample_en) begin
            state_d = ST_TRACK;
        end
    end

    // ---------------- output / datapath logic ----------------
    // 4-bit subtraction gives the mod-16 step directly, so F->0 is +1 and
    // 0->F is -1 without any special casing.
    assign step     = Q_in - prev_q;
    assign hold_inc = (hold_cnt_q == 4'hF) ? hold_cnt_q : hold_cnt_q + 4'd1;

    always_comb begin
        prev_d       = prev_q;
        hold_cnt_d   = hold_cnt_q;
        step_valid_d = 1'b0;
        dir_up_d     = dir_up_q;
        paused_d     = paused_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        seg_d        = seg_q;

        if (sample_en) begin
            seg_d  = seg_decode(Q_in);
            // prev follows every capture, including illegal steps, so the
            // monitor resynchronises to whatever the counter now shows.
            prev_d = Q_in;

            if (state_q == ST_TRACK) begin
                step_valid_d = 1'b1;
                case (step)
                    4'd0: begin
                        hold_cnt_d = hold_inc;
                        paused_d   = (hold_inc >= HOLD_LIM);
                    end
                    4'd1: begin
                        dir_up_d   = 1'b1;
                        hold_cnt_d = 4'd0;
                        paused_d   = 1'b0;
                    end
                    4'd15: begin
                        dir_up_d   = 1'b0;
                        hold_cnt_d = 4'd0;
                        paused_d   = 1'b0;
                    end
                    default: begin
                        err_d      = 1'b1;
                        hold_cnt_d = 4'd0;
                        paused_d   = 1'b0;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            prev_q       <= 4'd0;
            hold_cnt_q   <= 4'd0;
            step_valid_q <= 1'b0;
            dir_up_q     <= 1'b1;
            paused_q     <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            seg_q        <= SEG_ZERO;
        end else begin
            prev_q       <= prev_d;
            hold_cnt_q   <= hold_cnt_d;
            step_valid_q <= step_valid_d;
            dir_up_q     <= dir_up_d;
            paused_q     <= paused_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            seg_q        <= seg_d;
        end
    end

    assign step_valid = step_valid_q;
    assign dir_up     = dir_up_q;
    assign paused     = paused_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_count_step_monitor.sv
// Testbench for count_step_monitor. Two instances share one stimulus stream:
// dut_a (HOLD_LIMIT=3, ERR_W=2) and dut_b (HOLD_LIMIT=1, ERR_W=8). A small
// behavioural model tracks the sampled history and predicts both.

module tb_count_step_monitor;

    logic       CLK;
    logic       CLR;
    logic       sample_en;
    logic [3:0] Q_in;

    logic       sv_a, dir_a, pau_a, err_a;
    logic [1:0] cnt_a;
    logic [6:0] seg_a;
    logic       sv_b, dir_b, pau_b, err_b;
    logic [7:0] cnt_b;
    logic [6:0] seg_b;

    count_step_monitor #(.HOLD_LIMIT(3), .ERR_W(2)) dut_a (
        .CLK(CLK), .CLR(CLR), .sample_en(sample_en), .Q_in(Q_in),
        .step_valid(sv_a), .dir_up(dir_a), .paused(pau_a), .err(err_a),
        .err_count(cnt_a), .seg(seg_a)
    );

    count_step_monitor #(.HOLD_LIMIT(1), .ERR_W(8)) dut_b (
        .CLK(CLK), .CLR(CLR), .sample_en(sample_en), .Q_in(Q_in),
        .step_valid(sv_b), .dir_up(dir_b), .paused(pau_b), .err(err_b),
        .err_count(cnt_b), .seg(seg_b)
    );

    wire [12:0] obs_a = {sv_a, dir_a, pau_a, err_a, cnt_a, seg_a};
    wire [18:0] obs_b = {sv_b, dir_b, pau_b, err_b, cnt_b, seg_b};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    logic [6:0] seg_ref [16];
    bit  m_have, m_sv, m_err, m_dir;
    int  m_prev, m_zero, m_nerr, m_seg;
    logic [12:0] exp_a;
    logic [18:0] exp_b;

    task automatic compute_expect();
        int ca, cb;
        ca = (m_nerr > 3)   ? 3   : m_nerr;
        cb = (m_nerr > 255) ? 255 : m_nerr;
        exp_a = {m_sv, m_dir, (m_zero >= 3), m_err, 2'(ca), seg_ref[m_seg]};
        exp_b = {m_sv, m_dir, (m_zero >= 1), m_err, 8'(cb), seg_ref[m_seg]};
    endtask

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_zero = 0; m_dir = 1;
        m_nerr = 0; m_seg = 0;  m_sv = 0;   m_err = 0;
        compute_expect();
    endtask

    // Drive one strobe, let it be captured, and advance the model.
    // Returns at posedge+1 with sample_en low.
    task automatic drive_strobe(input logic [3:0] v);
        int d;
        @(negedge CLK);
        sample_en = 1'b1;
        Q_in      = v;
        @(posedge CLK);
        #1;
        sample_en = 1'b0;
        m_seg = int'(v);
        m_sv  = 0;
        m_err = 0;
        if (!m_have) begin
            m_have = 1;
        end else begin
            d = (int'(v) - m_prev + 16) % 16;
            m_sv = 1;
            if (d == 0) begin
                if (m_zero < 15) m_zero++;
            end else if (d == 1) begin
                m_dir = 1; m_zero = 0;
            end else if (d == 15) begin
                m_dir = 0; m_zero = 0;
            end else begin
                m_err = 1; m_nerr++; m_zero = 0;
            end
        end
        m_prev = int'(v);
        compute_expect();
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
        m_sv  = 0;
        m_err = 0;
        compute_expect();
    endtask

    task automatic apply_reset();
        CLR = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge CLK);
        CLR = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        repeat (2) @(posedge CLK);
        #1;
        // A strobe while reset is held must be ignored.
        sample_en = 1'b1;
        Q_in      = 4'h9;
        @(posedge CLK);
        #1;
        sample_en = 1'b0;
        checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL test_reset a: got %b want %b", obs_a, exp_a); end
        checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL test_reset b: got %b want %b", obs_b, exp_b); end
        checks++; if (seg_a !== 7'b1000000) begin errors++; $display("FAIL test_reset seg: got %b want 1000000", seg_a); end
        checks++; if (dir_b !== 1'b1) begin errors++; $display("FAIL test_reset dir_up: got %b want 1", dir_b); end
        release_reset();
    endtask

    task automatic test_count_up();
        logic [3:0] vals [4];
        vals = '{4'h3, 4'h4, 4'h5, 4'h6};
        apply_reset();
        release_reset();
        for (int i = 0; i < 4; i++) begin
            drive_strobe(vals[i]);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL test_count_up a[%0d]: got %b want %b", i, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL test_count_up b[%0d]: got %b want %b", i, obs_b, exp_b); end
            if (i == 0) begin
                checks++; if (sv_a !== 1'b0 || seg_a !== 7'b0110000) begin errors++; $display("FAIL test_count_up first: got sv=%b seg=%b want sv=0 seg=0110000", sv_a, seg_a); end
            end else begin
                checks++; if ({sv_a, dir_a, pau_a, err_a} !== 4'b1100) begin errors++; $display("FAIL test_count_up up[%0d]: got %b want 1100", i, {sv_a, dir_a, pau_a, err_a}); end
            end
        end
        checks++; if (seg_b !== 7'b0000010) begin errors++; $display("FAIL test_count_up final seg: got %b want 0000010", seg_b); end
        idle_cycle();
        checks++; if (sv_a !== 1'b0 || sv_b !== 1'b0) begin errors++; $display("FAIL test_count_up pulse: got sv=%b%b want 00", sv_a, sv_b); end
    endtask

    task automatic test_wrap();
        logic [3:0] vals [9];
        bit         dirs [9];
        vals = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h1, 4'h0, 4'hF, 4'hE, 4'hE};
        dirs = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
        apply_reset();
        release_reset();
        for (int i = 0; i < 8; i++) begin
            drive_strobe(vals[i]);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL test_wrap a[%0d]: got %b want %b", i, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL test_wrap b[%0d]: got %b want %b", i, obs_b, exp_b); end
            checks++; if (dir_a !== dirs[i] || err_a !== 1'b0) begin errors++; $display("FAIL test_wrap dir[%0d]: got dir=%b err=%b want dir=%b err=0", i, dir_a, err_a, dirs[i]); end
        end
        checks++; if (cnt_b !== 8'd0) begin errors++; $display("FAIL test_wrap err_count: got %0d want 0", cnt_b); end
    endtask

    task automatic test_hold();
        logic [3:0] vals [5];
        bit         pa   [5];
        vals = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h8};
        pa   = '{0, 0, 0, 1, 0};
        apply_reset();
        release_reset();
        for (int i = 0; i < 5; i++) begin
            drive_strobe(vals[i]);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL test_hold a[%0d]: got %b want %b", i, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL test_hold b[%0d]: got %b want %b", i, obs_b, exp_b); end
            checks++; if (pau_a !== pa[i]) begin errors++; $display("FAIL test_hold paused_a[%0d]: got %b want %b", i, pau_a, pa[i]); end
            idle_cycle();
            checks++; if (pau_a !== pa[i]) begin errors++; $display("FAIL test_hold paused_a held[%0d]: got %b want %b", i, pau_a, pa[i]); end
        end
        checks++; if (dir_a !== 1'b1) begin errors++; $display("FAIL test_hold dir_up: got %b want 1", dir_a); end
    endtask

    task automatic test_error();
        apply_reset();
        release_reset();
        drive_strobe(4'h2);
        drive_strobe(4'h9);
        checks++; if (err_a !== 1'b1 || cnt_a !== 2'd1 || cnt_b !== 8'd1) begin errors++; $display("FAIL test_error jump: got err=%b cnt=%0d/%0d want err=1 cnt=1/1", err_a, cnt_a, cnt_b); end
        idle_cycle();
        checks++; if (err_a !== 1'b0 || err_b !== 1'b0 || cnt_b !== 8'd1) begin errors++; $display("FAIL test_error pulse: got err=%b%b cnt=%0d want err=00 cnt=1", err_a, err_b, cnt_b); end
        drive_strobe(4'hA);
        checks++; if ({sv_b, dir_b, err_b} !== 3'b110 || cnt_b !== 8'd1) begin errors++; $display("FAIL test_error resync: got sv/dir/err=%b cnt=%0d want 110 cnt=1", {sv_b, dir_b, err_b}, cnt_b); end
        checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL test_error a: got %b want %b", obs_a, exp_a); end
    endtask

    task automatic test_saturate();
        logic [1:0] ea [5];
        ea = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        apply_reset();
        release_reset();
        drive_strobe(4'h0);
        for (int i = 0; i < 5; i++) begin
            drive_strobe((i % 2 == 0) ? 4'h8 : 4'h0);
            checks++; if (err_a !== 1'b1 || cnt_a !== ea[i]) begin errors++; $display("FAIL test_saturate a[%0d]: got err=%b cnt=%0d want err=1 cnt=%0d", i, err_a, cnt_a, ea[i]); end
            checks++; if (cnt_b !== 8'(i + 1)) begin errors++; $display("FAIL test_saturate b[%0d]: got cnt=%0d want %0d", i, cnt_b, i + 1); end
        end
    endtask

    task automatic test_midreset();
        apply_reset();
        release_reset();
        drive_strobe(4'h3);
        drive_strobe(4'h9);
        #2;
        apply_reset();
        #1;
        checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL test_midreset a: got %b want %b", obs_a, exp_a); end
        checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL test_midreset b: got %b want %b", obs_b, exp_b); end
        release_reset();
        drive_strobe(4'h5);
        checks++; if (sv_b !== 1'b0 || seg_b !== 7'b0010010) begin errors++; $display("FAIL test_midreset capture: got sv=%b seg=%b want sv=0 seg=0010010", sv_b, seg_b); end
        drive_strobe(4'h6);
        checks++; if ({sv_b, dir_b, err_b} !== 3'b110) begin errors++; $display("FAIL test_midreset up: got %b want 110", {sv_b, dir_b, err_b}); end
    endtask

    // Random stream: biased towards legal steps, with idle gaps (or none,
    // giving back-to-back strobes) and occasional mid-stream resets.
    task automatic test_random();
        int r;
        logic [3:0] v;
        apply_reset();
        release_reset();
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2)      v = 4'(m_prev);
            else if (r <= 4) v = 4'(m_prev + 1);
            else if (r <= 6) v = 4'(m_prev + 15);
            else             v = 4'($urandom_range(0, 15));
            drive_strobe(v);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL test_random a[%0d]: got %b want %b", i, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL test_random b[%0d]: got %b want %b", i, obs_b, exp_b); end
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
                checks++; if (obs_a !== exp_a || obs_b !== exp_b) begin errors++; $display("FAIL test_random idle[%0d]: got %b/%b want %b/%b", i, obs_a, obs_b, exp_a, exp_b); end
            end
            if ($urandom_range(0, 59) == 0) begin
                #2;
                apply_reset();
                #1;
                checks++; if (obs_a !== exp_a || obs_b !== exp_b) begin errors++; $display("FAIL test_random reset[%0d]: got %b/%b want %b/%b", i, obs_a, obs_b, exp_a, exp_b); end
                release_reset();
            end
        end
    endtask

    initial begin
        seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        CLR       = 1'b0;
        sample_en = 1'b0;
        Q_in      = 4'h0;
        model_reset();

        test_reset();
        test_count_up();
        test_wrap();
        test_hold();
        test_error();
        test_saturate();
        test_midreset();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
